// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling display shift register: mode encodings,
// the per-cell next-state select, and a constant clog2 helper.
package scroll_pkg;

   localparam logic [1:0] MODE_LOAD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   typedef enum logic [1:0] {
      SEL_PAR  = 2'b00,
      SEL_HI   = 2'b01,
      SEL_LO   = 2'b10,
      SEL_SELF = 2'b11
   } cell_sel_e;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/shift_cell.sv
// One storage bit of the scroll register with a 4:1 next-state select
// (parallel data, higher neighbour, lower neighbour, hold).
module shift_cell
   import scroll_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  cell_sel_e sel_i,
   input  logic      par_i,
   input  logic      hi_i,
   input  logic      lo_i,
   output logic      q_o
);

   logic q_d;
   logic q_q;

   always_comb begin
      q_d = q_q;
      unique case (sel_i)
         SEL_PAR:  q_d = par_i;
         SEL_HI:   q_d = hi_i;
         SEL_LO:   q_d = lo_i;
         SEL_SELF: q_d = q_q;
         default:  q_d = q_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else         q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/scroll_shift_reg.sv
// Multi-row universal shift register for the display panel with rotate/serial
// fill, scroll position tracking and a built-in scroll-rate prescaler.
module scroll_shift_reg
   import scroll_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int ROWS      = 7,
   parameter int DIV_WIDTH = 16
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                mode,
   input  logic                      rotate,
   input  logic                      auto_en,
   input  logic                      step,
   input  logic [DIV_WIDTH-1:0]      div_val,
   input  logic [ROWS-1:0]           ser_in_r,
   input  logic [ROWS-1:0]           ser_in_l,
   input  logic [ROWS*WIDTH-1:0]     par_in,
   output logic [ROWS*WIDTH-1:0]     q,
   output logic [clog2(WIDTH)-1:0]   pos,
   output logic                      tick,
   output logic                      wrap
);

   localparam int             PW      = clog2(WIDTH);
   localparam logic [PW-1:0]  POS_MAX = PW'(WIDTH - 1);

   logic [ROWS*WIDTH-1:0] q_q;
   logic [PW-1:0]         pos_q, pos_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  tick_q, tick_d;
   logic                  wrap_q, wrap_d;
   logic                  load, shr, shl, advance, run;
   cell_sel_e             sel;

   assign load    = (mode == MODE_LOAD);
   assign shr     = (mode == MODE_SHR);
   assign shl     = (mode == MODE_SHL);
   // The registered tick paces auto scrolling, so a shift lands one edge after tick.
   assign advance = auto_en ? tick_q : step;
   assign run     = auto_en && (shr || shl);

   always_comb begin
      sel = SEL_SELF;
      if (load)                 sel = SEL_PAR;
      else if (advance && shr)  sel = SEL_HI;
      else if (advance && shl)  sel = SEL_LO;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < WIDTH; c++) begin : g_col
         logic hi;
         logic lo;
         if (c == WIDTH - 1) begin : g_msb
            assign hi = rotate ? q_q[r*WIDTH] : ser_in_r[r];
         end else begin : g_hi
            assign hi = q_q[r*WIDTH + c + 1];
         end
         if (c == 0) begin : g_lsb
            assign lo = rotate ? q_q[r*WIDTH + WIDTH - 1] : ser_in_l[r];
         end else begin : g_lo
            assign lo = q_q[r*WIDTH + c - 1];
         end
         shift_cell u_cell (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .sel_i  (sel),
            .par_i  (par_in[r*WIDTH + c]),
            .hi_i   (hi),
            .lo_i   (lo),
            .q_o    (q_q[r*WIDTH + c])
         );
      end
   end

   // A >= compare lets a lowered div_val take effect on the very next edge.
   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (run) begin
         if (cnt_q >= div_val) tick_d = 1'b1;
         else                  cnt_d  = cnt_q + 1'b1;
      end

      pos_d  = pos_q;
      wrap_d = 1'b0;
      if (load) begin
         pos_d = '0;
      end else if (advance && shr) begin
         wrap_d = (pos_q == POS_MAX);
         pos_d  = wrap_d ? '0 : pos_q + 1'b1;
      end else if (advance && shl) begin
         wrap_d = (pos_q == '0);
         pos_d  = wrap_d ? POS_MAX : pos_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         pos_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         pos_q  <= pos_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign pos  = pos_q;
   assign tick = tick_q;
   assign wrap = wrap_q;

endmodule
